trng_entropy_reader: RTL and testbench

// Consumer-side companion of the TRNG control unit: starts the TRNG, captures each 32-bit word on the
// one-cycle rnd_ready pulse, returns ack_read, and buffers words in a small FIFO.

---
 rtl/trng_pkg.sv | 18 +
 rtl/trng_rd_fifo.sv | 67 ++++++
 rtl/trng_entropy_reader.sv | 158 +++++++++++++++
 tb/tb_trng_entropy_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types for the TRNG entropy reader: FSM states, failure codes and word width.
package trng_pkg;

    localparam int unsigned TrngW = 32;

    typedef enum logic [1:0] {
        StOff,
        StRun,
        StFail
    } rdr_state_e;

    typedef enum logic [1:0] {
        FailNone    = 2'd0,
        FailDead    = 2'd1,
        FailTimeout = 2'd2
    } fail_code_e;

endpackage

// File: rtl/trng_rd_fifo.sv
// Small synchronous show-ahead FIFO with synchronous flush; Depth must be a power of two.
module trng_rd_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = (count_q == CntW'(Depth));
        empty_o = (count_q == '0);
        rdata_o = mem_q[rptr_q];
        do_pop  = pop_i & ~empty_o;
        // A full FIFO can still take a word in the cycle it gives one up.
        do_push = push_i & (~full_o | do_pop);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/trng_entropy_reader.sv
// Consumer side of the TRNG: starts it, captures and acknowledges words, buffers them and
// serves 1..16-word requests; dead-TRNG and starvation failures are sticky until reset.
module trng_entropy_reader
    import trng_pkg::*;
#(
    parameter int unsigned DATA_W      = TrngW,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    output logic              trng_enable_o,
    input  logic              rnd_ready_i,
    input  logic [DATA_W-1:0] rnd_data_i,
    input  logic              trng_intr_i,
    output logic              ack_read_o,
    input  logic              req_i,
    input  logic [3:0]        req_len_i,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              fail_o,
    output logic [1:0]        fail_code_o
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    rdr_state_e        state_q, state_d;
    fail_code_e        fail_code_q, fail_code_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pend_q, pend_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              busy_q, busy_d;
    logic [4:0]        remaining_q, remaining_d;
    logic              trng_en_q, trng_en_d;

    logic              in_run, dead, wd_count, timeout, fail_now;
    logic              capture, push, pop, req_acc;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    trng_rd_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fail_now),
        .push_i  (push),
        .wdata_i (hold_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        in_run   = (state_q == StRun);
        dead     = in_run & trng_intr_i & ~rnd_ready_i;
        wd_count = in_run & ~pend_q & ~fifo_full;
        timeout  = wd_count & ~rnd_ready_i & (wd_q == WdW'(TIMEOUT_CYC - 1));
        fail_now = dead | timeout;

        // Ack only a word already held, never one arriving this cycle.
        push    = in_run & pend_q & ~fifo_full & ~fail_now;
        capture = in_run & rnd_ready_i & ~pend_q & ~fail_now;

        out_valid_o = busy_q & ~fifo_empty & ~fail_now;
        out_last_o  = out_valid_o & (remaining_q == 5'd1);
        out_data_o  = out_valid_o ? fifo_rdata : '0;
        pop         = out_valid_o & out_ready_i;
        req_acc     = req_i & ~busy_q & (state_q != StFail);

        ack_read_o    = push;
        trng_enable_o = trng_en_q;
        busy_o        = busy_q;
        fail_o        = (state_q == StFail);
        fail_code_o   = fail_code_q;
    end

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        trng_en_d   = 1'b0;
        hold_d      = hold_q;
        pend_d      = pend_q;
        wd_d        = wd_q;
        busy_d      = busy_q;
        remaining_d = remaining_q;

        unique case (state_q)
            StOff: begin
                if (enable_i) begin
                    state_d   = StRun;
                    trng_en_d = 1'b1;
                end
            end
            StRun: begin
                if (fail_now) begin
                    state_d     = StFail;
                    fail_code_d = dead ? FailDead : FailTimeout;
                end
            end
            StFail:  state_d = StFail;
            default: state_d = StFail;
        endcase

        if (capture) begin
            hold_d = rnd_data_i;
            pend_d = 1'b1;
            wd_d   = '0;
        end else begin
            if (push)     pend_d = 1'b0;
            if (wd_count) wd_d   = wd_q + WdW'(1);
        end

        if (req_acc) begin
            busy_d      = 1'b1;
            remaining_d = {1'b0, req_len_i} + 5'd1;
        end else if (pop) begin
            remaining_d = remaining_q - 5'd1;
            if (remaining_q == 5'd1) busy_d = 1'b0;
        end

        if (fail_now) begin
            hold_d      = '0;
            pend_d      = 1'b0;
            busy_d      = 1'b0;
            remaining_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StOff;
            fail_code_q <= FailNone;
            trng_en_q   <= 1'b0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            trng_en_q   <= trng_en_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_trng_entropy_reader.sv
// Directed bench for trng_entropy_reader: start-up, capture/ack, backpressure, failures, wrap.
module tb_trng_entropy_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        trng_enable;
    logic        rnd_ready;
    logic [31:0] rnd_data;
    logic        trng_intr;
    logic        ack_read;
    logic        req;
    logic [3:0]  req_len;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        fail;
    logic [1:0]  fail_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trng_entropy_reader #(
        .DATA_W      (32),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (4096)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .trng_enable_o (trng_enable),
        .rnd_ready_i   (rnd_ready),
        .rnd_data_i    (rnd_data),
        .trng_intr_i   (trng_intr),
        .ack_read_o    (ack_read),
        .req_i         (req),
        .req_len_i     (req_len),
        .busy_o        (busy),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_last_o    (out_last),
        .fail_o        (fail),
        .fail_code_o   (fail_code)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        rnd_ready = 1'b0;
        rnd_data  = '0;
        trng_intr = 1'b0;
        req       = 1'b0;
        req_len   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_trng();
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic feed_word(input logic [31:0] w);
        rnd_ready = 1'b1;
        rnd_data  = w;
        tick();
        rnd_ready = 1'b0;
        tick();
    endtask

    task automatic issue_req(input logic [3:0] len);
        req     = 1'b1;
        req_len = len;
        tick();
        req = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst    = 1'b1;
        enable = 1'b1;
        tick();
        total++;
        if ({trng_enable, ack_read, busy, out_valid, out_last, fail} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {trng_enable, ack_read, busy, out_valid, out_last, fail});
        end
        total++;
        if (out_data !== 32'h0 || fail_code !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: got data=%h code=%0d want 0/0", out_data, fail_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_enable();
        int pulses;
        apply_reset();
        enable = 1'b1;
        tick();
        total++;
        if (trng_enable !== 1'b1) begin
            bad++;
            $display("FAIL enable_pulse: got %b want 1", trng_enable);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (trng_enable === 1'b1) pulses++;
            if (i == 3) enable = 1'b0;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL enable_repeat: got %0d extra pulses want 0", pulses);
        end
    endtask

    task automatic test_single();
        apply_reset();
        start_trng();
        rnd_ready = 1'b1;
        rnd_data  = 32'hA5A5_0001;
        total++;
        if (ack_read !== 1'b0) begin
            bad++;
            $display("FAIL single_ack_capture: got %b want 0", ack_read);
        end
        tick();
        rnd_ready = 1'b0;
        total++;
        if (ack_read !== 1'b1) begin
            bad++;
            $display("FAIL single_ack_next: got %b want 1", ack_read);
        end
        tick();
        total++;
        if (ack_read !== 1'b0) begin
            bad++;
            $display("FAIL single_ack_once: got %b want 0", ack_read);
        end
        issue_req(4'd0);
        total++;
        if ({busy, out_valid, out_last} !== 3'b111 || out_data !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL single_beat: got bvl=%b data=%h want 111 a5a50001",
                     {busy, out_valid, out_last}, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL single_done: got busy/valid=%b want 00", {busy, out_valid});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = 32'hB000_0000 + 32'(i * 17 + 3);
        apply_reset();
        start_trng();
        for (int i = 0; i < 4; i++) feed_word(w[i]);
        rnd_ready = 1'b1;
        rnd_data  = w[4];
        tick();
        rnd_ready = 1'b0;
        total++;
        if (ack_read !== 1'b0) begin
            bad++;
            $display("FAIL bp_ack_full: got %b want 0", ack_read);
        end
        // A pulse while a word is still held must be dropped without an ack.
        rnd_ready = 1'b1;
        rnd_data  = 32'hDEAD_BEEF;
        tick();
        rnd_ready = 1'b0;
        tick();
        total++;
        if (ack_read !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: got ack=%b valid=%b want 0/0", ack_read, out_valid);
        end
        issue_req(4'd4);
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            total++;
            if (out_valid !== 1'b1 || out_data !== w[k] || out_last !== (k == 4)) begin
                bad++;
                $display("FAIL bp_word%0d: got v=%b d=%h l=%b want 1 %h %b",
                         k, out_valid, out_data, out_last, w[k], (k == 4));
            end
            total++;
            if (ack_read !== (k == 1)) begin
                bad++;
                $display("FAIL bp_ack%0d: got %b want %b", k, ack_read, (k == 1));
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL bp_done: got busy/valid=%b want 00", {busy, out_valid});
        end
    endtask

    task automatic test_dead();
        apply_reset();
        start_trng();
        for (int i = 0; i < 4; i++) feed_word(32'h1111_0000 + 32'(i));
        issue_req(4'd4);
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b1;
            total++;
            if (out_data !== 32'h1111_0000 + 32'(k)) begin
                bad++;
                $display("FAIL dead_pre%0d: got %h want %h", k, out_data, 32'h1111_0000 + 32'(k));
            end
            tick();
        end
        out_ready = 1'b0;
        trng_intr = 1'b1;
        tick();
        trng_intr = 1'b0;
        total++;
        if ({fail, out_valid, out_last, busy, ack_read} !== 5'b10000 || fail_code !== 2'd1) begin
            bad++;
            $display("FAIL dead_entry: got fvlba=%b code=%0d want 10000 1",
                     {fail, out_valid, out_last, busy, ack_read}, fail_code);
        end
        rnd_ready = 1'b1;
        rnd_data  = 32'h7777_7777;
        tick();
        rnd_ready = 1'b0;
        total++;
        if (ack_read !== 1'b0) begin
            bad++;
            $display("FAIL dead_no_ack: got %b want 0", ack_read);
        end
        issue_req(4'd0);
        total++;
        if (busy !== 1'b0 || fail !== 1'b1 || fail_code !== 2'd1) begin
            bad++;
            $display("FAIL dead_sticky: got busy=%b fail=%b code=%0d want 0 1 1",
                     busy, fail, fail_code);
        end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        enable = 1'b1;
        tick();
        n = 0;
        while (fail !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (n !== 4096) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d want 4096", n);
        end
        total++;
        if (fail !== 1'b1 || fail_code !== 2'd2) begin
            bad++;
            $display("FAIL timeout_code: got fail=%b code=%0d want 1 2", fail, fail_code);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({trng_enable, ack_read, busy, out_valid, out_last, fail, fail_code} !== 8'b0) begin
            bad++;
            $display("FAIL rst_mid: got %b want 00000000",
                     {trng_enable, ack_read, busy, out_valid, out_last, fail, fail_code});
        end
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        total++;
        if (trng_enable !== 1'b1) begin
            bad++;
            $display("FAIL rst_to_off: got enable pulse %b want 1", trng_enable);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        start_trng();
        issue_req(4'd8);
        for (int k = 0; k < 9; k++) begin
            rnd_ready = 1'b1;
            rnd_data  = 32'hC0DE_0000 + 32'(k);
            tick();
            rnd_ready = 1'b0;
            out_ready = 1'b1;
            total++;
            if (ack_read !== 1'b1) begin
                bad++;
                $display("FAIL wrap_ack%0d: got %b want 1", k, ack_read);
            end
            total++;
            if (k == 0) begin
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_empty: got valid %b want 0", out_valid);
                end
            end else if (out_valid !== 1'b1 || out_data !== 32'hC0DE_0000 + 32'(k - 1) ||
                         out_last !== 1'b0) begin
                bad++;
                $display("FAIL wrap_word%0d: got v=%b d=%h l=%b want 1 %h 0",
                         k - 1, out_valid, out_data, out_last, 32'hC0DE_0000 + 32'(k - 1));
            end
            tick();
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hC0DE_0008 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL wrap_last: got v=%b d=%h l=%b want 1 c0de0008 1",
                     out_valid, out_data, out_last);
        end
        tick();
        out_ready = 1'b0;
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL wrap_done: got busy/valid=%b want 00", {busy, out_valid});
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_single();
        test_backpressure();
        test_dead();
        test_timeout();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
